pattern_lut_arbiter: RTL

//  Shares LUT read port 1 of the pattern LUT between the pattern finder (2nd CLCT candidate) and a VME/host readback requester.

---
 rtl/pattern_lut_arbiter_if.sv | 35 +++
 rtl/pattern_lut_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/pattern_lut_arbiter_if.sv
// pattern_lut_arbiter_if: pattern-finder, LUT port and host handshake signals of the LUT arbiter
interface pattern_lut_arbiter_if #(
    parameter int MXADRB = 12,
    parameter int MXDATB = 18,
    parameter int MXPIDB = 4
);
    logic              pf_vld0;
    logic [MXADRB-1:0] pf_adr0;
    logic [MXPIDB-1:0] pf_pid0;
    logic              pf_vld1;
    logic [MXADRB-1:0] pf_adr1;
    logic [MXPIDB-1:0] pf_pid1;
    logic [MXADRB-1:0] lut_adr0;
    logic [MXPIDB-1:0] lut_pid0;
    logic [MXADRB-1:0] lut_adr1;
    logic [MXPIDB-1:0] lut_pid1;
    logic [MXDATB-1:0] lut_rd1;
    logic              host_req;
    logic [MXPIDB-1:0] host_pid;
    logic [MXADRB-1:0] host_adr;
    logic              host_busy;
    logic              host_ack;
    logic [MXDATB-1:0] host_data;
    logic              host_err;
    logic              pf_drop1;
    logic [15:0]       cnt_drop;
    modport slave (
        input  pf_vld0, pf_adr0, pf_pid0, pf_vld1, pf_adr1, pf_pid1, lut_rd1, host_req, host_pid, host_adr,
        output lut_adr0, lut_pid0, lut_adr1, lut_pid1, host_busy, host_ack, host_data, host_err, pf_drop1, cnt_drop
    );
    modport master (
        output pf_vld0, pf_adr0, pf_pid0, pf_vld1, pf_adr1, pf_pid1, lut_rd1, host_req, host_pid, host_adr,
        input  lut_adr0, lut_pid0, lut_adr1, lut_pid1, host_busy, host_ack, host_data, host_err, pf_drop1, cnt_drop
    );
endinterface

// File: rtl/pattern_lut_arbiter.sv
// pattern_lut_arbiter: shares pattern LUT read port 1 between pattern-finder candidate 1 and a host reader
module pattern_lut_arbiter #(
    parameter int MXADRB     = 12,
    parameter int MXDATB     = 18,
    parameter int MXPIDB     = 4,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    pattern_lut_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OWN, S_ACK} state_t;
    state_t            r_state, w_next;
    logic [MXPIDB-1:0] r_pid;
    logic [MXADRB-1:0] r_adr;
    logic [7:0]        r_wait;
    logic [1:0]        r_own;
    logic [MXDATB-1:0] r_data;
    logic              r_err;
    logic [15:0]       r_cnt_drop;
    logic              w_pid_ok, w_accept, w_grant, w_own1, w_drop, w_capture;

    // next state, port 1 ownership and candidate-1 drop detection
    always_comb begin
        w_pid_ok  = (bus.host_pid >= MXPIDB'(2)) && (bus.host_pid <= MXPIDB'(10));
        w_accept  = (r_state == S_IDLE) && bus.host_req;
        w_grant   = (r_state == S_WAIT) && (!bus.pf_vld1 || r_wait == 8'(STARVE_MAX));
        w_own1    = (r_state == S_OWN) || w_grant;
        w_drop    = w_own1 && bus.pf_vld1;
        w_capture = (r_state == S_OWN) && (r_own == 2'd1);
        w_next    = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_pid_ok ? S_WAIT : S_ACK) : S_IDLE;
            S_WAIT:  w_next = w_grant ? S_OWN : S_WAIT;
            S_OWN:   w_next = w_capture ? S_ACK : S_OWN;
            S_ACK:   w_next = bus.host_req ? S_ACK : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.lut_adr0  = bus.pf_adr0;
    assign bus.lut_pid0  = bus.pf_pid0;
    assign bus.lut_adr1  = w_own1 ? r_adr : bus.pf_adr1;
    assign bus.lut_pid1  = w_own1 ? r_pid : bus.pf_pid1;
    assign bus.host_busy = (r_state == S_WAIT) || (r_state == S_OWN);
    assign bus.host_ack  = (r_state == S_ACK);
    assign bus.host_data = r_data;
    assign bus.host_err  = r_err;
    assign bus.pf_drop1  = w_drop;
    assign bus.cnt_drop  = r_cnt_drop;

    // state, latched request, starvation/ownership counters, read data and drop count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pid      <= '0;
            r_adr      <= '0;
            r_wait     <= '0;
            r_own      <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_cnt_drop <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pid <= bus.host_pid;
                r_adr <= bus.host_adr;
                if (!w_pid_ok) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
            r_wait <= (r_state == S_WAIT && !w_grant) ? r_wait + {7'd0, r_wait != 8'(STARVE_MAX)} : 8'd0;
            r_own  <= w_grant ? 2'(ROM_LAT) : (r_state == S_OWN) ? r_own - 2'd1 : r_own;
            if (w_capture)
                r_data <= bus.lut_rd1;
            if (r_state == S_ACK && !bus.host_req)
                r_err <= 1'b0;
            if (w_drop && r_cnt_drop != 16'hFFFF)
                r_cnt_drop <= r_cnt_drop + 16'd1;
        end
    end
endmodule
